iterative_shifter: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the MIPS datapath. It is the successor to the fixed left-shift-by-two branch-offset shifter. It takes a variable shift amount, supports logical-left, logical-right, arithmetic-right and rotate-left, and shifts at most STEP bits per clock so a wide barrel shifter is not needed. It is driven by the control unit through a start/busy/done handshake and serves SLL/SRL/SRA/SLLV/SRLV/SRAV as well as branch/jump offset scaling.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shift_step.sv | 34 +++
 rtl/iterative_shifter.sv | 104 ++++++++++
 tb/tb_iterative_shifter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation modes and FSM states.
`default_nettype none

package shifter_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves din by amt (0..STEP) bits in the selected mode.
`default_nettype none

module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(STEP + 1)
) (
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [2*WIDTH-1:0] rot;

  always_comb begin
    // Rotating the doubled word left leaves the rotated value in the upper half.
    rot  = {din, din} << amt;
    dout = din;
    case (mode)
      SH_SLL:  dout = din << amt;
      SH_SRL:  dout = din >> amt;
      SH_SRA:  dout = $signed(din) >>> amt;
      SH_ROTL: dout = rot[2*WIDTH-1:WIDTH];
      default: dout = din;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: consumes at most STEP bits of the shift amount per clock.
`default_nettype none

module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(STEP + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic             last;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] step_out;

  // The final step is the one that can absorb everything still outstanding.
  always_comb begin
    last = (int'(rem_q) <= STEP);
    amt  = last ? AW'(rem_q) : AW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .mode (mode_q),
    .amt  (amt),
    .din  (data_q),
    .dout (step_out)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data_in;
          mode_d  = mode;
          rem_d   = shamt;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - SW'(amt);
        if (last) begin
          done_d   = 1'b1;
          result_d = step_out;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      mode_q   <= SH_SLL;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// Self-checking bench: three instances (STEP=1, 4, 32) with a per-instance scoreboard.
`timescale 1ns/1ps

module tb_iterative_shifter;
  import shifter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start;
  logic [1:0]   mode;
  logic [4:0]   shamt;
  logic [W-1:0] data_in;
  logic         busy_o [3];
  logic         done_o [3];
  logic [W-1:0] res_o  [3];

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(W), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy_o[0]), .done(done_o[0]), .result(res_o[0]));
  iterative_shifter #(.WIDTH(W), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy_o[1]), .done(done_o[1]), .result(res_o[1]));
  iterative_shifter #(.WIDTH(W), .STEP(32)) u32 (
    .clk(clk), .rst(rst), .start(start[2]), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy_o[2]), .done(done_o[2]), .result(res_o[2]));

  typedef struct {
    logic [W-1:0] res;
    int           k;
    int           n;
  } exp_t;

  typedef struct {
    logic [1:0]   m;
    int           sh;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;

  exp_t sb [3][$];
  int   steps [3] = '{1, 4, 32};
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [1:0] m, input int sh, input logic [W-1:0] d);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = W'($signed(d) >>> sh);
      default: r = (sh == 0) ? d : ((d << sh) | (d >> (W - sh)));
    endcase
    return r;
  endfunction

  function automatic int n_of(input int sh, input int step);
    return (sh == 0) ? 1 : (sh + step - 1) / step;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (done_o[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst=%0d: got done=1, expected done=0", i);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk($sformatf("result inst=%0d", i), res_o[i], e.res);
            chk($sformatf("latency inst=%0d", i), W'(cyc - e.k), W'(e.n));
            chk($sformatf("busy_at_done inst=%0d", i), W'(busy_o[i]), W'(0));
          end
        end
      end
    end
  end

  task automatic launch(input logic [2:0] mask, input logic [1:0] m, input int sh,
                        input logic [W-1:0] d, input logic [W-1:0] exp, input bit push);
    mode    = m;
    shamt   = sh[4:0];
    data_in = d;
    start   = mask;
    @(posedge clk);
    #1;
    start = 3'b000;
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          exp_t e;
          e.res = exp;
          e.k   = cyc;
          e.n   = n_of(sh, steps[i]);
          sb[i].push_back(e);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done within 200 cycles, expected done");
      for (int i = 0; i < 3; i++) sb[i].delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = '{SH_SLL,  2,  32'h0000_0001, 32'h0000_0004};
    tbl[1] = '{SH_SRA,  31, 32'h8000_0000, 32'hFFFF_FFFF};
    tbl[2] = '{SH_SRL,  31, 32'h8000_0000, 32'h0000_0001};
    tbl[3] = '{SH_ROTL, 4,  32'h8000_0001, 32'h0000_0018};
    tbl[4] = '{SH_ROTL, 0,  32'h8000_0001, 32'h8000_0001};
    tbl[5] = '{SH_SLL,  8,  32'h0000_00FF, 32'h0000_FF00};

    rst = 1'b1;
    start = 3'b000;
    mode = SH_SLL;
    shamt = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", W'(busy_o[1]), W'(0));
    chk("reset done", W'(done_o[1]), W'(0));
    chk("reset result", res_o[1], W'(0));
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      launch(3'b111, tbl[v].m, tbl[v].sh, tbl[v].d, tbl[v].exp, 1'b1);
      wait_idle();
    end

    // start while busy must be ignored
    launch(3'b010, SH_SLL, 20, 32'h0000_0001, 32'h0010_0000, 1'b1);
    repeat (2) @(negedge clk);
    launch(3'b010, SH_SRL, 3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("still_busy", W'(busy_o[1]), W'(1));
    wait_idle();
    repeat (8) @(negedge clk);

    // start in the done cycle is accepted
    launch(3'b010, SH_SRA, 8, 32'hF000_0000, 32'hFFF0_0000, 1'b1);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!done_o[1] && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    launch(3'b010, SH_ROTL, 12, 32'h1234_5678, 32'h4567_8123, 1'b1);
    chk("accepted_in_done_cycle", W'(busy_o[1]), W'(1));
    wait_idle();

    // reset in the middle of an operation aborts it
    launch(3'b010, SH_SLL, 20, 32'hFFFF_FFFF, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", W'(busy_o[1]), W'(0));
    chk("abort done", W'(done_o[1]), W'(0));
    chk("abort result", res_o[1], W'(0));
    repeat (10) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      for (int sh = 0; sh < 32; sh++) begin
        logic [W-1:0] d;
        d = $urandom;
        launch(3'b111, m[1:0], sh, d, ref_model(m[1:0], sh, d), 1'b1);
        wait_idle();
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
